alu_vec_q88: RTL and testbench
==============================

// Module: alu_vec_q88
// PURPOSE
//  16-lane SIMD ALU on signed Q8.8 fixed-point (16-bit lanes, 256-bit vectors) for the vector execute stage.
//  Performs lane-wise MUL/ADD/SUB/logic/SET.
//  Scalar mode confines the operation to lane 0.
//  Result and per-lane flags are registered (1-cycle latency) and feed vector register writeback.
// PARAMETERS
//  LANES   16  number of lanes (fixed; ports sized for 16)
//  LW      16  lane width in bits
//  FRAC    8   fractional bits (Q8.8)
// PORTS
//  clk          in   1    single clock, all state on rising edge
//  rst          in   1    reset, synchronous, active-low
//  a            in   256  vector operand A; lane i = a[16i+15:16i]
//  b            in   256  vector operand B, same lane map
//  c            in   16   scalar immediate for SET
//  opcode       in   3    operation select
//  flag_scalar  in   1    1 = scalar op on lane 0 only; 0 = all 16 lanes
//  result       out  256  registered result vector
//  flags        out  64   registered flags; lane i nibble flags[4i+3:4i] = {N,Z,C,V}
// BEHAVIOUR
//  - rst==0 at posedge: result=0, flags=0. Otherwise result/flags <= combinational value of current inputs.
//  - Latency 1 cycle, throughput 1 op/cycle, no handshake; inputs sampled every posedge.
//  - Opcodes:
//      000 MUL: p = a_i*b_i signed 32b; r = p[23:8] (truncate); V = p[31:23] not all equal; C = 0
//      001 reserved: r = 0, flags 0
//      010 ADD: r = a_i+b_i mod 2^16; C = unsigned carry out; V = signed overflow
//      011 SUB: r = a_i-b_i mod 2^16; C = NOT borrow; V = signed overflow
//      100 AND, 101 OR, 110 XOR: bitwise; C = V = 0
//      111 SET: r = c; C = V = 0
//  - N = r[15]; Z = (r == 0), for every opcode.
//  - Arithmetic wraps, no saturation.
//  - flag_scalar=1: lane 0 computed as above; lanes 1..15 result = 0 and flag nibbles = 0 (also for SET).
//  - Lanes are fully independent: no cross-lane carry.
//  - Reset asserted with valid inputs: reset wins.
// STRUCTURE
//  - Package alu_vec_pkg holds: LANES/LW/FRAC constants, opcode enum (OP_MUL..OP_SET), flag bit indices N=3 Z=2 C=1 V=0.
//  - Sub-module alu_lane_q88: combinational single-lane ALU (a,b,c,opcode -> r,flags).
//  - Top generates 16 lanes, applies scalar masking, owns the output registers.
// TESTING (lane0 listed last; lanes 7..1 = 0x0000 in a and b)
//  a = 0180_0140_0380_0180_0080_0300_0140_0000..._0140
//  b = FE40_0180_0200_0340_05C0_FF80_FE80_0000..._FE80
//  1. MUL vector -> lanes15..9 = FD60 01E0 0700 04E0 02E0 FE80 FE20;
//     lanes 8..1 = 0000 (Z=1); lane0 = FE20 (N=1).
//  2. MUL scalar -> result = 0...0_FE20; flags = 0...0_1000.
//  3. ADD vector -> lanes15..9 = FFC0 02C0 0580 04C0 0640 0280 FFC0; lane0 = FFC0;
//     lane15 flags N=1 C=0; lane13 C=0; lane10 {N,Z,C,V}=0010 (0300+FF80 carries).
//  4. ADD scalar -> result = 0...0_FFC0; flags = 0...0_1000.
//  5. SET vector, c = FF00 -> all 16 lanes FF00, every nibble 1000;
//     SET scalar -> lane0 only = FF00.
//  6. Overflow/reset: ADD 7FFF+0001 -> 8000, flags 1001;
//     MUL 7F00*0200 -> V=1;
//     rst=0 for one cycle mid-stream -> result=0, flags=0 at next edge, resumes after.
//  Check every result one cycle after inputs change.

Source files
------------

// File: rtl/alu_vec_pkg.sv
// Purpose: shared constants, opcode encoding and flag bit positions for the Q8.8 vector ALU.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package alu_vec_pkg;

    localparam int LANES = 16;
    localparam int LW    = 16;
    localparam int FRAC  = 8;

    typedef enum logic [2:0] {
        OP_MUL  = 3'b000,
        OP_RSVD = 3'b001,
        OP_ADD  = 3'b010,
        OP_SUB  = 3'b011,
        OP_AND  = 3'b100,
        OP_OR   = 3'b101,
        OP_XOR  = 3'b110,
        OP_SET  = 3'b111
    } opcode_e;

    // Bit positions inside each lane's {N,Z,C,V} nibble.
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

endpackage

// File: rtl/alu_lane_q88.sv
// Purpose: one signed Q8.8 lane: MUL/ADD/SUB/AND/OR/XOR/SET with {N,Z,C,V} flags.
// Latency: purely combinational, registered by the parent.
// Backpressure: none; evaluates its current inputs continuously.
module alu_lane_q88
    import alu_vec_pkg::*;
(
    input  logic [LW-1:0] a,
    input  logic [LW-1:0] b,
    input  logic [LW-1:0] c,
    input  logic [2:0]    opcode,
    output logic [LW-1:0] r,
    output logic [3:0]    flags
);

    logic signed [2*LW-1:0] prod;
    logic [LW:0]            sum;
    logic [LW:0]            diff;
    logic [FRAC-1:0]        prod_frac_unused;
    logic                   c_flag;
    logic                   v_flag;
    logic                   flags_en;

    assign prod = $signed(a) * $signed(b);
    // Fractional bits below the Q8.8 point are dropped by truncation.
    assign prod_frac_unused = prod[FRAC-1:0];
    // 17-bit forms expose carry-out (ADD) and not-borrow (SUB) in the top bit.
    assign sum  = {1'b0, a} + {1'b0, b};
    assign diff = {1'b0, a} + {1'b0, ~b} + {{LW{1'b0}}, 1'b1};

    // Opcode decode: lane result plus carry/overflow; N and Z derive from the result.
    always_comb begin
        r        = '0;
        c_flag   = 1'b0;
        v_flag   = 1'b0;
        flags_en = 1'b1;
        case (opcode_e'(opcode))
            OP_MUL: begin
                r      = prod[FRAC+LW-1:FRAC];
                // Overflow when the bits above the kept window are not a pure sign extension.
                v_flag = !((&prod[2*LW-1:FRAC+LW-1]) || !(|prod[2*LW-1:FRAC+LW-1]));
            end
            OP_ADD: begin
                r      = sum[LW-1:0];
                c_flag = sum[LW];
                v_flag = (a[LW-1] == b[LW-1]) && (sum[LW-1] != a[LW-1]);
            end
            OP_SUB: begin
                r      = diff[LW-1:0];
                c_flag = diff[LW];
                v_flag = (a[LW-1] != b[LW-1]) && (diff[LW-1] != a[LW-1]);
            end
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_XOR:  r = a ^ b;
            OP_SET:  r = c;
            default: flags_en = 1'b0;
        endcase
    end

    // Reserved opcode reports a clean all-zero nibble rather than Z=1.
    always_comb begin
        flags         = '0;
        flags[FLAG_N] = flags_en & r[LW-1];
        flags[FLAG_Z] = flags_en & (r == '0);
        flags[FLAG_C] = flags_en & c_flag;
        flags[FLAG_V] = flags_en & v_flag;
    end

endmodule

// File: rtl/alu_vec_q88.sv
// Purpose: 16-lane Q8.8 SIMD ALU with scalar (lane 0 only) mode for vector execute.
// Latency: 1 cycle, result and flags registered; one op accepted every cycle.
// Backpressure: none; inputs are sampled on every rising edge.
module alu_vec_q88
    import alu_vec_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic [LANES*LW-1:0]   a,
    input  logic [LANES*LW-1:0]   b,
    input  logic [LW-1:0]         c,
    input  logic [2:0]            opcode,
    input  logic                  flag_scalar,
    output logic [LANES*LW-1:0]   result,
    output logic [LANES*4-1:0]    flags
);

    logic [LW-1:0]        lane_r [LANES];
    logic [3:0]           lane_f [LANES];
    logic [LANES*LW-1:0]  result_nxt;
    logic [LANES*4-1:0]   flags_nxt;

    genvar g;
    for (g = 0; g < LANES; g++) begin : g_lane
        alu_lane_q88 u_lane (
            .a      (a[g*LW +: LW]),
            .b      (b[g*LW +: LW]),
            .c      (c),
            .opcode (opcode),
            .r      (lane_r[g]),
            .flags  (lane_f[g])
        );
    end

    // Pack lanes; in scalar mode only lane 0 survives, others read as all-zero.
    always_comb begin
        result_nxt = '0;
        flags_nxt  = '0;
        for (int i = 0; i < LANES; i++) begin
            if (!flag_scalar || (i == 0)) begin
                result_nxt[i*LW +: LW] = lane_r[i];
                flags_nxt[i*4 +: 4]    = lane_f[i];
            end
        end
    end

    // Output register; active-low synchronous reset overrides any op in flight.
    always_ff @(posedge clk) begin
        if (!rst) begin
            result <= '0;
            flags  <= '0;
        end else begin
            result <= result_nxt;
            flags  <= flags_nxt;
        end
    end

endmodule

// File: tb/tb_alu_vec_q88.sv
// Purpose: self-checking bench for alu_vec_q88: vector table, reset sequences, random ops.
// Latency: expects each op's result one clock after it is driven.
// Backpressure: none; a new op is driven every cycle.
module tb_alu_vec_q88;

    logic         clk = 1'b0;
    logic         rst;
    logic [255:0] a;
    logic [255:0] b;
    logic [15:0]  c;
    logic [2:0]   opcode;
    logic         flag_scalar;
    logic [255:0] result;
    logic [63:0]  flags;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [255:0] er;
        logic [63:0]  ef;
        int           tag;
    } exp_t;

    typedef struct {
        logic [2:0]   op;
        logic         sc;
        logic [255:0] av;
        logic [255:0] bv;
        logic [15:0]  cv;
        logic [255:0] er;
        logic [63:0]  ef;
    } vec_t;

    exp_t sb[$];
    vec_t tbl[$];

    always #5 clk = ~clk;

    alu_vec_q88 dut (
        .clk         (clk),
        .rst         (rst),
        .a           (a),
        .b           (b),
        .c           (c),
        .opcode      (opcode),
        .flag_scalar (flag_scalar),
        .result      (result),
        .flags       (flags)
    );

    // Independent reference: integer arithmetic with range checks for overflow.
    function automatic void model(input logic [255:0] av, input logic [255:0] bv,
                                  input logic [15:0] cv, input logic [2:0] ov, input logic sv,
                                  output logic [255:0] rr, output logic [63:0] ff);
        rr = '0;
        ff = '0;
        for (int i = 0; i < 16; i++) begin
            logic [15:0] x;
            logic [15:0] y;
            logic [15:0] r;
            logic n, z, cf, vf;
            int sx, sy, ux, uy, t;
            longint p;
            x = av[16*i +: 16];
            y = bv[16*i +: 16];
            sx = int'($signed(x));
            sy = int'($signed(y));
            ux = int'(x);
            uy = int'(y);
            r = '0; cf = 1'b0; vf = 1'b0;
            case (ov)
                3'd0: begin
                    p  = longint'(sx) * longint'(sy);
                    r  = p[23:8];
                    vf = (p > longint'(8388607)) || (p < -longint'(8388608));
                end
                3'd2: begin
                    t = ux + uy; r = t[15:0]; cf = (t > 65535);
                    t = sx + sy; vf = (t > 32767) || (t < -32768);
                end
                3'd3: begin
                    t = ux - uy; r = t[15:0]; cf = (ux >= uy);
                    t = sx - sy; vf = (t > 32767) || (t < -32768);
                end
                3'd4: r = x & y;
                3'd5: r = x | y;
                3'd6: r = x ^ y;
                3'd7: r = cv;
                default: r = '0;
            endcase
            n = r[15];
            z = (r == 16'h0);
            if (ov == 3'd1) begin n = 1'b0; z = 1'b0; end
            if (sv && (i != 0)) begin
                r = '0; n = 1'b0; z = 1'b0; cf = 1'b0; vf = 1'b0;
            end
            rr[16*i +: 16] = r;
            ff[4*i +: 4]   = {n, z, cf, vf};
        end
    endfunction

    task automatic check_out();
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            if (result !== e.er) begin
                errors++;
                $display("FAIL result tag%0d got %h want %h", e.tag, result, e.er);
            end
            checks++;
            if (flags !== e.ef) begin
                errors++;
                $display("FAIL flags tag%0d got %h want %h", e.tag, flags, e.ef);
            end
        end
    endtask

    // One cycle: compare the previous op's registered output, then drive the next op.
    task automatic step(input logic rv, input logic [255:0] av, input logic [255:0] bv,
                        input logic [15:0] cv, input logic [2:0] ov, input logic sv,
                        input logic [255:0] er, input logic [63:0] ef, input int tag);
        exp_t e;
        @(negedge clk);
        check_out();
        rst = rv; a = av; b = bv; c = cv; opcode = ov; flag_scalar = sv;
        e.er = er; e.ef = ef; e.tag = tag;
        sb.push_back(e);
    endtask

    task automatic add_vec(input logic [2:0] op, input logic sc, input logic [255:0] av,
                           input logic [255:0] bv, input logic [15:0] cv,
                           input logic [255:0] er, input logic [63:0] ef);
        vec_t v;
        v.op = op; v.sc = sc; v.av = av; v.bv = bv; v.cv = cv; v.er = er; v.ef = ef;
        tbl.push_back(v);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "bench timed out");
    end

    initial begin : main
        logic [255:0] va, vb, mr, rr;
        logic [63:0]  mf, ff;
        logic [15:0]  corner [5];
        logic [2:0]   rop;
        logic         rsc;
        logic [15:0]  rc;

        va = 256'h0180_0140_0380_0180_0080_0300_0140_0000_0000_0000_0000_0000_0000_0000_0000_0140;
        vb = 256'hFE40_0180_0200_0340_05C0_FF80_FE80_0000_0000_0000_0000_0000_0000_0000_0000_FE80;
        corner[0] = 16'h0000; corner[1] = 16'h7FFF; corner[2] = 16'h8000;
        corner[3] = 16'hFFFF; corner[4] = 16'h0001;

        rst = 1'b0; a = '0; b = '0; c = '0; opcode = '0; flag_scalar = 1'b0;

        // Worked examples with hand-derived expectations.
        add_vec(3'd0, 1'b0, va, vb, 16'h0,
                256'hFD60_01E0_0700_04E0_02E0_FE80_FE20_0000_0000_0000_0000_0000_0000_0000_0000_FE20,
                64'h8000_0884_4444_4448);
        add_vec(3'd0, 1'b1, va, vb, 16'h0, 256'hFE20, 64'h8);
        add_vec(3'd2, 1'b0, va, vb, 16'h0,
                256'hFFC0_02C0_0580_04C0_0640_0280_FFC0_0000_0000_0000_0000_0000_0000_0000_0000_FFC0,
                64'h8000_0284_4444_4448);
        add_vec(3'd2, 1'b1, va, vb, 16'h0, 256'hFFC0, 64'h8);
        add_vec(3'd7, 1'b0, va, vb, 16'hFF00, {16{16'hFF00}}, 64'h8888_8888_8888_8888);
        add_vec(3'd7, 1'b1, va, vb, 16'hFF00, 256'hFF00, 64'h8);
        add_vec(3'd2, 1'b1, 256'h7FFF, 256'h0001, 16'h0, 256'h8000, 64'h9);
        add_vec(3'd0, 1'b1, 256'h7F00, 256'h0200, 16'h0, 256'hFE00, 64'h9);
        add_vec(3'd1, 1'b0, va, vb, 16'h1234, 256'h0, 64'h0);
        // Remaining opcodes on the same operands, expectations from the reference model.
        for (int k = 3; k <= 6; k++) begin
            model(va, vb, 16'h0, 3'(k), 1'b0, mr, mf);
            add_vec(3'(k), 1'b0, va, vb, 16'h0, mr, mf);
        end
        model(va, vb, 16'h0, 3'd3, 1'b1, mr, mf);
        add_vec(3'd3, 1'b1, va, vb, 16'h0, mr, mf);

        // Reset state: two reset cycles, second compares the first.
        step(1'b0, '0, '0, '0, 3'd0, 1'b0, '0, '0, 100);
        step(1'b0, va, vb, 16'hFF00, 3'd2, 1'b0, '0, '0, 101);

        foreach (tbl[i])
            step(1'b1, tbl[i].av, tbl[i].bv, tbl[i].cv, tbl[i].op, tbl[i].sc,
                 tbl[i].er, tbl[i].ef, i);

        // Mid-stream reset: reset wins over a valid op, then the stream resumes.
        model(va, vb, 16'h0, 3'd2, 1'b0, mr, mf);
        step(1'b1, va, vb, 16'h0, 3'd2, 1'b0, mr, mf, 200);
        step(1'b0, va, vb, 16'h0, 3'd0, 1'b0, '0, '0, 201);
        model(va, vb, 16'h0, 3'd0, 1'b0, mr, mf);
        step(1'b1, va, vb, 16'h0, 3'd0, 1'b0, mr, mf, 202);
        model(va, vb, 16'h0, 3'd3, 1'b0, mr, mf);
        step(1'b1, va, vb, 16'h0, 3'd3, 1'b0, mr, mf, 203);

        // Random back-to-back ops with a bias toward overflow-prone lane values.
        for (int n = 0; n < 60; n++) begin
            for (int l = 0; l < 16; l++) begin
                va[16*l +: 16] = ($urandom_range(0, 2) == 0) ? corner[$urandom_range(0, 4)]
                                                             : 16'($urandom());
                vb[16*l +: 16] = ($urandom_range(0, 2) == 0) ? corner[$urandom_range(0, 4)]
                                                             : 16'($urandom());
            end
            rop = 3'($urandom_range(0, 7));
            rsc = ($urandom_range(0, 3) == 0);
            rc  = 16'($urandom());
            model(va, vb, rc, rop, rsc, rr, ff);
            step(1'b1, va, vb, rc, rop, rsc, rr, ff, 300 + n);
        end

        @(negedge clk);
        check_out();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain left %0d want 0", sb.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
